// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: EX-side bundle for the HI/LO multiply/divide unit (master = EX stage, slave = sequencer)
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             MfReq;
  logic             MtWe;
  logic             HiLoSel;
  logic [WIDTH-1:0] MtData;
  logic [WIDTH-1:0] MfData;
  logic             Stall;
  logic             Busy;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  modport master (output Start, Op, A, B, MfReq, MtWe, HiLoSel, MtData,
                  input  MfData, Stall, Busy, Hi, Lo);
  modport slave  (input  Start, Op, A, B, MfReq, MtWe, HiLoSel, MtData,
                  output MfData, Stall, Busy, Hi, Lo);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: bit-serial MIPS mult/multu/div/divu with HI/LO, mf/mt access and EX stall (Clk, Reset async high, bus = slave side)
module muldiv_sequencer #(parameter int WIDTH = 32) (
  input logic Clk,
  input logic Reset,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               q_sign;
  logic               r_sign;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     r_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  always_comb begin
    sgn     = ~bus.Op[0];
    a_mag   = (sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_mag   = (sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    // multiply: acc = {partial, multiplier}, add multiplicand on LSB then shift right
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    // divide: acc = {remainder, dividend/quotient}, shift left and trial-subtract
    r_sh    = acc[2*WIDTH-1:WIDTH-1];
    diff    = r_sh - {1'b0, m};
    step    = !is_div ? {mul_sum, acc[WIDTH-1:1]}
            : diff[WIDTH] ? {r_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
            : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod    = q_sign ? -acc : acc;
    res_hi  = !is_div ? prod[2*WIDTH-1:WIDTH]
            : r_sign ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    // divide by zero forces an all-ones quotient; the remainder already equals A
    res_lo  = !is_div ? prod[WIDTH-1:0]
            : (m == '0) ? '1
            : q_sign ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      q_sign <= 1'b0;
      r_sign <= 1'b0;
      m      <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            is_div <= bus.Op[1];
            q_sign <= sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            r_sign <= sgn & bus.A[WIDTH-1];
            m      <= bus.Op[1] ? b_mag : a_mag;
            acc    <= {{WIDTH{1'b0}}, bus.Op[1] ? a_mag : b_mag};
            cnt    <= CW'(WIDTH);
            state  <= RUN;
          end else if (bus.MtWe) begin
            if (bus.HiLoSel) hi <= bus.MtData;
            else lo <= bus.MtData;
          end
        end
        RUN: begin
          acc <= step;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        default: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= IDLE;
        end
      endcase
    end
  end
  assign bus.Busy   = state != IDLE;
  assign bus.Stall  = (state != IDLE) && (bus.Start || bus.MfReq || bus.MtWe);
  assign bus.MfData = bus.HiLoSel ? hi : lo;
  assign bus.Hi     = hi;
  assign bus.Lo     = lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed checks of muldiv_sequencer arithmetic, timing, stall, mt/mf and async reset
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   n;
  always #5 clk = ~clk;
  muldiv_sequencer_if #(.WIDTH(32)) bus ();
  muldiv_sequencer #(.WIDTH(32)) dut (.Clk(clk), .Reset(rst), .bus(bus));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
    bus.Op = op;
    bus.A = a;
    bus.B = b;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    cyc = 0;
    while (bus.Busy && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask
  task automatic wait_stall(output int cyc);
    cyc = 0;
    while (bus.Stall && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.Start = 1'b0;
    bus.Op = 2'b00;
    bus.A = '0;
    bus.B = '0;
    bus.MfReq = 1'b0;
    bus.MtWe = 1'b0;
    bus.HiLoSel = 1'b0;
    bus.MtData = '0;
    tick();
    tick();
    chk("reset_hi", bus.Hi, 32'h0);
    chk("reset_lo", bus.Lo, 32'h0);
    chk("reset_busy", {31'b0, bus.Busy}, 32'h0);
    chk("reset_stall", {31'b0, bus.Stall}, 32'h0);
    rst = 1'b0;
    tick();
    run_op(2'b00, 32'hFFFFFFFD, 32'd7, n);
    chk("mult_busy_cycles", n, 32'd33);
    chk("mult_hi", bus.Hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.Lo, 32'hFFFFFFEB);
    run_op(2'b01, 32'hFFFFFFFF, 32'd2, n);
    chk("multu_hi", bus.Hi, 32'h00000001);
    chk("multu_lo", bus.Lo, 32'hFFFFFFFE);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, n);
    chk("div_lo", bus.Lo, 32'hFFFFFFFD);
    chk("div_hi", bus.Hi, 32'hFFFFFFFF);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, n);
    chk("div_ovf_lo", bus.Lo, 32'h80000000);
    chk("div_ovf_hi", bus.Hi, 32'h0);
    run_op(2'b10, 32'hFFFFFFF9, 32'h0, n);
    chk("div0_signed_lo", bus.Lo, 32'hFFFFFFFF);
    chk("div0_signed_hi", bus.Hi, 32'hFFFFFFF9);
    run_op(2'b11, 32'h1234, 32'h0, n);
    chk("divu0_busy_cycles", n, 32'd33);
    chk("divu0_lo", bus.Lo, 32'hFFFFFFFF);
    chk("divu0_hi", bus.Hi, 32'h00001234);
    run_op(2'b11, 32'd100, 32'd7, n);
    chk("divu_lo", bus.Lo, 32'd14);
    chk("divu_hi", bus.Hi, 32'd2);
    bus.Op = 2'b00;
    bus.A = 32'd5;
    bus.B = 32'd6;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    bus.MfReq = 1'b1;
    bus.HiLoSel = 1'b0;
    chk("mflo_old_lo_held", bus.Lo, 32'd14);
    wait_stall(n);
    chk("mflo_stall_cycles", n, 32'd33);
    chk("mflo_no_stall_idle", {31'b0, bus.Stall}, 32'h0);
    chk("mflo_data", bus.MfData, 32'd30);
    bus.HiLoSel = 1'b1;
    #1;
    chk("mfhi_data", bus.MfData, 32'd0);
    bus.MfReq = 1'b0;
    bus.MtWe = 1'b1;
    bus.HiLoSel = 1'b0;
    bus.MtData = 32'hAAAA5555;
    #1;
    chk("mtlo_no_stall", {31'b0, bus.Stall}, 32'h0);
    tick();
    bus.MtWe = 1'b0;
    chk("mtlo_lo", bus.Lo, 32'hAAAA5555);
    bus.Op = 2'b00;
    bus.A = 32'd3;
    bus.B = 32'd4;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    tick();
    tick();
    tick();
    chk("run_lo_held", bus.Lo, 32'hAAAA5555);
    bus.MtWe = 1'b1;
    bus.HiLoSel = 1'b1;
    bus.MtData = 32'h00001357;
    #1;
    chk("mthi_stall_run", {31'b0, bus.Stall}, 32'h1);
    wait_stall(n);
    chk("mthi_stall_cycles", n, 32'd30);
    chk("mthi_prod_hi", bus.Hi, 32'd0);
    chk("mthi_prod_lo", bus.Lo, 32'd12);
    tick();
    bus.MtWe = 1'b0;
    chk("mthi_hi", bus.Hi, 32'h00001357);
    bus.Op = 2'b00;
    bus.A = 32'd9;
    bus.B = 32'd9;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    repeat (9) tick();
    bus.MfReq = 1'b1;
    #1;
    chk("pre_reset_stall", {31'b0, bus.Stall}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_stall", {31'b0, bus.Stall}, 32'h0);
    chk("async_rst_busy", {31'b0, bus.Busy}, 32'h0);
    chk("async_rst_hi", bus.Hi, 32'h0);
    chk("async_rst_lo", bus.Lo, 32'h0);
    rst = 1'b0;
    bus.MfReq = 1'b0;
    tick();
    run_op(2'b00, 32'd2, 32'd3, n);
    chk("post_rst_busy_cycles", n, 32'd33);
    chk("post_rst_lo", bus.Lo, 32'd6);
    chk("post_rst_hi", bus.Hi, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
